// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and helpers for the register_file_p register bank.
//   DEFAULT_WIDTH / DEFAULT_NREG : default word width and word count
//   MAX_WIDTH / MAX_BYTES        : widest word the byte-merge helper handles
//   byte_merge()                 : stored word + write data + byte enables
//                                  -> merged word. It is used by both the
//                                  storage write path and the read bypass.
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_NREG  = 8;

  // The helper is written once at a fixed maximum width. Callers size-cast
  // into it and back out, so every WIDTH up to MAX_WIDTH shares one body.
  localparam int MAX_WIDTH = 1024;
  localparam int MAX_BYTES = MAX_WIDTH / 8;

  // A byte comes from wdata where its enable is set, otherwise from stored.
  function automatic logic [MAX_WIDTH-1:0] byte_merge(
    input logic [MAX_WIDTH-1:0] stored,
    input logic [MAX_WIDTH-1:0] wdata,
    input logic [MAX_BYTES-1:0] wbe
  );
    logic [MAX_WIDTH-1:0] merged;
    merged = stored;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (wbe[i]) begin
        merged[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        merged[8*i +: 8] = stored[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/register_word.sv
// ---------------------------------------------------------------------------
// register_word
// One WIDTH-bit storage word. It has a synchronous active-low reset, a load
// enable and per-byte enables.
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   synchronous reset, active-low (clears the word)
//   load    in   write this word on the current edge
//   be      in   WIDTH/8 byte enables applied when load=1
//   d       in   WIDTH write data
//   q       out  WIDTH stored word (registered)
// ---------------------------------------------------------------------------
module register_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q
);

  logic [WIDTH-1:0] q_r;

  // Storage: clear on reset, otherwise merge enabled bytes on load.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_r <= {WIDTH{1'b0}};
    end else if (load) begin
      q_r <= WIDTH'(byte_merge(MAX_WIDTH'(q_r), MAX_WIDTH'(d), MAX_BYTES'(be)));
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/register_file_p.sv
// ---------------------------------------------------------------------------
// register_file_p
// Parametrised register file with NREG words of WIDTH bits. It has one
// byte-enabled write port and two independent registered read ports, each
// with 1-cycle latency and a valid flag.
// Optional build macro: REGFILE_WRITE_BYPASS_EN
//   defined   - a read of the address being written in the same cycle
//               returns the merged (post-write) word
//   undefined - such a read returns the pre-write stored word
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   we, waddr, wbe, wdata   write port (byte enables, WIDTH/8 bits)
//   re_a, raddr_a           read request / address, port A
//   re_b, raddr_b           read request / address, port B
//   rdata_a, rvalid_a       registered read data / valid, port A
//   rdata_b, rvalid_b       registered read data / valid, port B
// With ZERO_REG=1, word 0 ignores writes and always reads as zero.
// ---------------------------------------------------------------------------
module register_file_p
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int NREG     = DEFAULT_NREG,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               re_a,
  input  logic [AW-1:0]      raddr_a,
  input  logic               re_b,
  input  logic [AW-1:0]      raddr_b,
  output logic [WIDTH-1:0]   rdata_a,
  output logic               rvalid_a,
  output logic [WIDTH-1:0]   rdata_b,
  output logic               rvalid_b
);

  logic [WIDTH-1:0] words_s [NREG];
  logic [NREG-1:0]  load_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;
  logic [WIDTH-1:0] rdata_a_r;
  logic [WIDTH-1:0] rdata_b_r;
  logic             rvalid_a_r;
  logic             rvalid_b_r;

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : g_word
      // Word 0 never loads when it is hard-wired to zero.
      if ((g == 0) && (ZERO_REG != 0)) begin : g_zero
        assign load_s[g] = 1'b0;
      end else begin : g_load
        assign load_s[g] = we && (waddr == AW'(g));
      end

      register_word #(.WIDTH(WIDTH)) u_word (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_s[g]),
        .be      (wbe),
        .d       (wdata),
        .q       (words_s[g])
      );
    end
  endgenerate

  // Port A read value: stored word, optional same-cycle bypass, zero word.
  always_comb begin
    rd_a_s = words_s[raddr_a];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && (waddr == raddr_a)) begin
      rd_a_s = WIDTH'(byte_merge(MAX_WIDTH'(words_s[raddr_a]), MAX_WIDTH'(wdata),
                                 MAX_BYTES'(wbe)));
    end else begin
      rd_a_s = words_s[raddr_a];
    end
`endif
    // The zero word wins over the bypass so a discarded write never leaks out.
    if ((ZERO_REG != 0) && (raddr_a == {AW{1'b0}})) begin
      rd_a_s = {WIDTH{1'b0}};
    end else begin
      rd_a_s = rd_a_s;
    end
  end

  // Port B read value: same rules as port A.
  always_comb begin
    rd_b_s = words_s[raddr_b];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && (waddr == raddr_b)) begin
      rd_b_s = WIDTH'(byte_merge(MAX_WIDTH'(words_s[raddr_b]), MAX_WIDTH'(wdata),
                                 MAX_BYTES'(wbe)));
    end else begin
      rd_b_s = words_s[raddr_b];
    end
`endif
    if ((ZERO_REG != 0) && (raddr_b == {AW{1'b0}})) begin
      rd_b_s = {WIDTH{1'b0}};
    end else begin
      rd_b_s = rd_b_s;
    end
  end

  // Read output registers: data holds when idle, valid pulses per request.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_a_r  <= {WIDTH{1'b0}};
      rvalid_a_r <= 1'b0;
      rdata_b_r  <= {WIDTH{1'b0}};
      rvalid_b_r <= 1'b0;
    end else begin
      if (re_a) begin
        rdata_a_r  <= rd_a_s;
        rvalid_a_r <= 1'b1;
      end else begin
        rdata_a_r  <= rdata_a_r;
        rvalid_a_r <= 1'b0;
      end
      if (re_b) begin
        rdata_b_r  <= rd_b_s;
        rvalid_b_r <= 1'b1;
      end else begin
        rdata_b_r  <= rdata_b_r;
        rvalid_b_r <= 1'b0;
      end
    end
  end

  assign rdata_a  = rdata_a_r;
  assign rvalid_a = rvalid_a_r;
  assign rdata_b  = rdata_b_r;
  assign rvalid_b = rvalid_b_r;

endmodule

// File: tb/tb_register_file_p.sv
// ---------------------------------------------------------------------------
// tb_register_file_p
// Self-checking bench for register_file_p. Two instances share all inputs:
// one with ZERO_REG=0 and one with ZERO_REG=1. A behavioural array model
// predicts every read-port output each cycle. Directed scenarios come first,
// then randomized traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_register_file_p;

  localparam int WIDTH = 32;
  localparam int NREG  = 8;
  localparam int AW    = 3;
  localparam int NB    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [NB-1:0]    wbe;
  logic [WIDTH-1:0] wdata;
  logic             re_a;
  logic [AW-1:0]    raddr_a;
  logic             re_b;
  logic [AW-1:0]    raddr_b;

  logic [WIDTH-1:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic             rvalid_a0, rvalid_b0, rvalid_a1, rvalid_b1;

  int checks   = 0;
  int failures = 0;

  // Reference model state: index 0 = ZERO_REG=0 instance, 1 = ZERO_REG=1.
  logic [WIDTH-1:0] mem [2][NREG];
  logic [WIDTH-1:0] exp_rd_a [2];
  logic [WIDTH-1:0] exp_rd_b [2];
  logic             exp_rv_a [2];
  logic             exp_rv_b [2];

  always #5 clk = ~clk;

  register_file_p #(.WIDTH(WIDTH), .NREG(NREG), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rdata_a0), .rvalid_a(rvalid_a0), .rdata_b(rdata_b0), .rvalid_b(rvalid_b0)
  );

  register_file_p #(.WIDTH(WIDTH), .NREG(NREG), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rdata_a1), .rvalid_a(rvalid_a1), .rdata_b(rdata_b1), .rvalid_b(rvalid_b1)
  );

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] be_mask(input logic [NB-1:0] be);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) m = m | (32'hFF << (8 * i));
    end
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] model_read(input int z, input logic [AW-1:0] ra);
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] m;
    v = mem[z][ra];
    m = be_mask(wbe);
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && waddr == ra) v = (v & ~m) | (wdata & m);
`endif
    if (z == 1 && ra == 3'd0) v = '0;
    return v;
  endfunction

  // Apply the rules for one rising edge to both models, using current inputs.
  task automatic model_step();
    logic [WIDTH-1:0] m;
    m = be_mask(wbe);
    for (int z = 0; z < 2; z++) begin
      if (!reset_n) begin
        for (int k = 0; k < NREG; k++) mem[z][k] = '0;
        exp_rd_a[z] = '0;
        exp_rd_b[z] = '0;
        exp_rv_a[z] = 1'b0;
        exp_rv_b[z] = 1'b0;
      end else begin
        exp_rv_a[z] = re_a;
        exp_rv_b[z] = re_b;
        if (re_a) exp_rd_a[z] = model_read(z, raddr_a);
        if (re_b) exp_rd_b[z] = model_read(z, raddr_b);
        if (we && !(z == 1 && waddr == 3'd0))
          mem[z][waddr] = (mem[z][waddr] & ~m) | (wdata & m);
      end
    end
  endtask

  task automatic check_all();
    check_eq("z0_rdata_a",  rdata_a0,  exp_rd_a[0]);
    check_eq("z0_rvalid_a", {31'd0, rvalid_a0}, {31'd0, exp_rv_a[0]});
    check_eq("z0_rdata_b",  rdata_b0,  exp_rd_b[0]);
    check_eq("z0_rvalid_b", {31'd0, rvalid_b0}, {31'd0, exp_rv_b[0]});
    check_eq("z1_rdata_a",  rdata_a1,  exp_rd_a[1]);
    check_eq("z1_rvalid_a", {31'd0, rvalid_a1}, {31'd0, exp_rv_a[1]});
    check_eq("z1_rdata_b",  rdata_b1,  exp_rd_b[1]);
    check_eq("z1_rvalid_b", {31'd0, rvalid_b1}, {31'd0, exp_rv_b[1]});
  endtask

  // One clock: the model follows the edge, and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wbe = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    #2;
    // Reset held for two cycles.
    step();
    step();
    reset_n = 1'b1;
    re_a = 1'b1; raddr_a = 3'd5;
    step();
    check_eq("reset_read_data",  rdata_a0, 32'h0);
    check_eq("reset_read_valid", {31'd0, rvalid_a0}, 32'd1);

    // Full-word write, then read on port B.
    idle_inputs();
    we = 1'b1; waddr = 3'd3; wbe = 4'hF; wdata = 32'hDEADBEEF;
    step();
    idle_inputs();
    re_b = 1'b1; raddr_b = 3'd3;
    step();
    check_eq("full_write", rdata_b0, 32'hDEADBEEF);
    check_eq("full_write_valid", {31'd0, rvalid_b0}, 32'd1);

    // Byte-enabled write.
    idle_inputs();
    we = 1'b1; waddr = 3'd3; wbe = 4'b0101; wdata = 32'h11223344;
    step();
    idle_inputs();
    re_a = 1'b1; raddr_a = 3'd3;
    step();
    check_eq("byte_enable_write", rdata_a0, 32'hDE22BE44);

    // Write with no byte enables leaves the word alone.
    idle_inputs();
    we = 1'b1; waddr = 3'd3; wbe = 4'h0; wdata = 32'h0;
    step();
    idle_inputs();
    re_b = 1'b1; raddr_b = 3'd3;
    step();
    check_eq("wbe_zero_write", rdata_b0, 32'hDE22BE44);

    // Same-cycle read of the address being written.
    idle_inputs();
    we = 1'b1; waddr = 3'd2; wbe = 4'hF; wdata = 32'hCAFEF00D;
    re_a = 1'b1; raddr_a = 3'd2;
    step();
`ifdef REGFILE_WRITE_BYPASS_EN
    check_eq("read_during_write", rdata_a0, 32'hCAFEF00D);
`else
    check_eq("read_during_write", rdata_a0, 32'h00000000);
`endif
    idle_inputs();
    re_a = 1'b1; raddr_a = 3'd2;
    step();
    check_eq("read_after_write", rdata_a0, 32'hCAFEF00D);

    // Word 0 on the ZERO_REG instance.
    idle_inputs();
    we = 1'b1; waddr = 3'd0; wbe = 4'hF; wdata = 32'hFFFFFFFF;
    step();
    idle_inputs();
    re_a = 1'b1; raddr_a = 3'd0; re_b = 1'b1; raddr_b = 3'd0;
    step();
    check_eq("zero_reg_a", rdata_a1, 32'h0);
    check_eq("zero_reg_b", rdata_b1, 32'h0);
    check_eq("zero_reg_valid_a", {31'd0, rvalid_a1}, 32'd1);
    check_eq("zero_reg_valid_b", {31'd0, rvalid_b1}, 32'd1);
    check_eq("plain_reg0", rdata_a0, 32'hFFFFFFFF);

    // Idle port: valid drops and data holds.
    idle_inputs();
    step();
    check_eq("idle_hold_data", rdata_a0, 32'hFFFFFFFF);
    check_eq("idle_valid_low", {31'd0, rvalid_a0}, 32'd0);

    // Reset arrives one edge after a read; everything ignored and cleared.
    re_a = 1'b1; raddr_a = 3'd3;
    step();
    reset_n = 1'b0;
    we = 1'b1; waddr = 3'd4; wbe = 4'hF; wdata = 32'h12345678;
    re_b = 1'b1; raddr_b = 3'd3;
    step();
    check_eq("midreset_valid", {31'd0, rvalid_a0}, 32'd0);
    check_eq("midreset_data",  rdata_a0, 32'h0);
    reset_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < NREG; i++) begin
      re_a = 1'b1; raddr_a = AW'(i);
      re_b = 1'b1; raddr_b = AW'(NREG - 1 - i);
      step();
      check_eq("post_reset_word", rdata_a0, 32'h0);
    end

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      we      = $urandom_range(0, 1) != 0;
      waddr   = AW'($urandom_range(0, NREG - 1));
      wbe     = NB'($urandom);
      wdata   = $urandom;
      re_a    = $urandom_range(0, 3) != 0;
      re_b    = $urandom_range(0, 3) != 0;
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NREG - 1));
      raddr_b = ($urandom_range(0, 3) == 0) ? raddr_a : AW'($urandom_range(0, NREG - 1));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_p.md
Name: register_file_p

Overview:
- Parametrised register file, successor to the fixed-width clk-only register blocks.
- NREG words of WIDTH bits each, one write port with byte enables, two read ports.
- Read data is registered: 1-cycle latency, with a valid flag per read port.
- Used as the general-purpose register bank for the datapath and controller labs.

Parameters:
WIDTH, 32, word width in bits; must be a multiple of 8
NREG, 8, number of words; power of two, at least 2
AW, $clog2(NREG), address width (derived, not overridden)
ZERO_REG, 0, if 1 then word 0 reads as zero and ignores writes

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous reset, active-low
we  input  1  write enable
waddr  input  AW  write address
wbe  input  WIDTH/8  byte enables for the write
wdata  input  WIDTH  write data
re_a  input  1  read request, port A
raddr_a  input  AW  read address, port A
re_b  input  1  read request, port B
raddr_b  input  AW  read address, port B
rdata_a  output  WIDTH  read data, port A (registered)
rvalid_a  output  1  rdata_a valid, port A
rdata_b  output  WIDTH  read data, port B (registered)
rvalid_b  output  1  rdata_b valid, port B

Behaviour:
- Clock and reset: single clock domain on clk. Reset is synchronous and active-low: sampled only on the rising edge of clk while reset_n=0.
- Reset values: all words = 0; rdata_a = rdata_b = 0; rvalid_a = rvalid_b = 0.
- Reset dominates: any we, re_a or re_b in a reset cycle is ignored.
- Reset mid-operation: a pending read result is dropped; rvalid drops to 0 on the next edge.
- Write: on an edge with we=1, byte i of word[waddr] takes wdata[8i+7:8i] only where wbe[i]=1. Other bytes hold their value.
- we=1 with wbe=0 changes nothing.
- Read: on an edge with re_x=1, rdata_x <= word[raddr_x] and rvalid_x <= 1. Latency is 1 cycle.
- On an edge with re_x=0: rvalid_x <= 0 and rdata_x holds its last value (not cleared).
- Both read ports are independent. Same address on both ports is legal; both return the same data.
- ZERO_REG=1: writes to address 0 are discarded, and reads of address 0 return 0. This also holds in bypass mode.
- Read-during-write to the same address in the same cycle: behaviour is defined under Optional Feature.
- Address range: all addresses are in range by construction (NREG = 2^AW). There is no error path.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: a read whose raddr_x equals waddr while we=1 returns the merged word. Bytes with wbe=1 come from wdata; the remaining bytes come from the stored word. The result is still registered with 1-cycle latency.
- Undefined: the same read returns the pre-write stored word. The new value is visible to reads issued from the next cycle onward.

Decomposition:
- Package regfile_pkg holds:
  - default WIDTH and NREG constants;
  - the byte-merge function (stored, wdata, wbe) -> merged word, shared by the write path and the bypass path.
- Sub-module register_word: one WIDTH-bit register with synchronous active-low reset, load enable and byte enables. register_file_p instantiates NREG of them in a generate loop.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles, then re_a=1, raddr_a=5 -> next cycle rdata_a=0, rvalid_a=1.
- Full write: we=1, waddr=3, wbe=4'hF, wdata=32'hDEADBEEF; next cycle re_b=1, raddr_b=3 -> one cycle later rdata_b=32'hDEADBEEF, rvalid_b=1.
- Byte-enable write: word 3 = 32'hDEADBEEF, then wbe=4'b0101, wdata=32'h11223344 -> read of word 3 returns 32'hDE22BE44.
- Same-cycle read of the written address: we=1, waddr=2, wdata=32'hCAFEF00D with re_a=1, raddr_a=2, word 2 previously 0 -> rdata_a=32'hCAFEF00D with REGFILE_WRITE_BYPASS_EN defined, 32'h00000000 without it.
- ZERO_REG=1: write 32'hFFFFFFFF to address 0, then read address 0 on both ports -> rdata_a=rdata_b=0, rvalid_a=rvalid_b=1.
- Reset mid-read: re_a=1 at edge N and reset_n=0 at edge N+1 -> rvalid_a=0 and rdata_a=0 after edge N+1; all words read back as 0 after reset.
